// File: rtl/mux31_pkg.sv
// mux31_pkg: shared definitions for the 3:1 selector path.
//   - SEL_IN1/SEL_IN2/SEL_IN3: mux select encodings for in1/in2/in3.
//   - arb_state_t: arbiter state encoding (IDLE, GRANT).
//   - gnt_to_sel(): one-hot grant -> mux select.
//   - idx_to_onehot(): requester index -> one-hot grant vector.
package mux31_pkg;

    localparam logic [1:0] SEL_IN1 = 2'b00;
    localparam logic [1:0] SEL_IN2 = 2'b01;
    localparam logic [1:0] SEL_IN3 = 2'b10;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // An all-zero or malformed grant maps to SEL_IN1. Callers only pass
    // true one-hot values, so this default is never observed on `s`.
    function automatic logic [1:0] gnt_to_sel(input logic [2:0] g);
        logic [1:0] sel;
        case (g)
            3'b010:  sel = SEL_IN2;
            3'b100:  sel = SEL_IN3;
            default: sel = SEL_IN1;
        endcase
        return sel;
    endfunction

    function automatic logic [2:0] idx_to_onehot(input logic [1:0] idx);
        logic [2:0] oh;
        case (idx)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            default: oh = 3'b100;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/arb31_if.sv
// arb31_if: request/grant bundle between the three requesters and arb31.
//   req       requester -> arbiter, level-held request (bit i = in(i+1))
//   gnt       arbiter -> requesters, one-hot grant or 000
//   s         arbiter -> mux, select of the current/most recent owner
//   busy      arbiter -> requesters, high while gnt is non-zero
//   state_dbg arbiter -> observers, current FSM state
// Handshake: a requester raises req and holds it; it owns the mux output
// on every cycle its gnt bit is high, and drops req when it is done. There
// is no separate ready/ack, gnt alone is the transfer qualifier.
// modport master: requester side.  modport slave: arbiter side.
interface arb31_if;
    import mux31_pkg::*;

    logic [2:0] req;
    logic [2:0] gnt;
    logic [1:0] s;
    logic       busy;
    arb_state_t state_dbg;

    modport master (output req, input gnt, input s, input busy, input state_dbg);
    modport slave  (input req, output gnt, output s, output busy, output state_dbg);

endinterface

// File: rtl/rr_pick3.sv
// rr_pick3: combinational round-robin pick among three requesters.
//   req[2:0]     request vector
//   last[1:0]    most recent owner; search order is last+1, last+2, last (mod 3)
//   exclude[2:0] requesters masked out of this search
//   pick[1:0]    chosen index (equals last when nothing is found)
//   found        a candidate was chosen
module rr_pick3 (
    input  logic [2:0] req,
    input  logic [1:0] last,
    input  logic [2:0] exclude,
    output logic [1:0] pick,
    output logic       found
);

    logic [2:0] cand;
    logic [1:0] o0, o1, o2;

    always_comb begin
        cand = req & ~exclude;
        // Search order for each pointer value; last == 3 never occurs and
        // is folded onto last == 2.
        case (last)
            2'd0:    begin o0 = 2'd1; o1 = 2'd2; o2 = 2'd0; end
            2'd1:    begin o0 = 2'd2; o1 = 2'd0; o2 = 2'd1; end
            default: begin o0 = 2'd0; o1 = 2'd1; o2 = 2'd2; end
        endcase

        pick  = last;
        found = 1'b0;
        if (cand[o0]) begin
            pick  = o0;
            found = 1'b1;
        end else if (cand[o1]) begin
            pick  = o1;
            found = 1'b1;
        end else if (cand[o2]) begin
            pick  = o2;
            found = 1'b1;
        end
    end

endmodule

// File: rtl/arb31.sv
// arb31: round-robin arbiter in front of the 3:1 mux.
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   arb31_if.slave: req in; gnt, s, busy, state_dbg out (all registered)
// MAX_HOLD (1..15): cycles one owner may keep the grant while others wait.
module arb31
    import mux31_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic   clk,
    input  logic   rst,
    arb31_if.slave bus
);

    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    arb_state_t state;
    logic [1:0] owner;
    logic [1:0] last;
    logic [3:0] hold_cnt;
    logic [2:0] gnt_q;
    logic [1:0] s_q;
    logic       busy_q;

    logic [2:0] owner_oh;
    logic [2:0] others;
    logic [2:0] exclude;
    logic [1:0] pick;
    logic       found;
    logic       keep_owner;

    // One picker serves both cases: from IDLE nothing is excluded, in GRANT
    // the owner is excluded so the result is the handover/rotation target.
    always_comb begin
        owner_oh   = idx_to_onehot(owner);
        others     = bus.req & ~owner_oh;
        exclude    = (state == GRANT) ? owner_oh : 3'b000;
        keep_owner = bus.req[owner] && ((others == 3'b000) || (hold_cnt < HOLD_LAST));
    end

    rr_pick3 u_pick (
        .req     (bus.req),
        .last    (last),
        .exclude (exclude),
        .pick    (pick),
        .found   (found)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= 2'd0;
            last     <= 2'd2;
            hold_cnt <= 4'd0;
            gnt_q    <= 3'b000;
            s_q      <= SEL_IN1;
            busy_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state    <= GRANT;
                        owner    <= pick;
                        last     <= pick;
                        hold_cnt <= 4'd0;
                        gnt_q    <= idx_to_onehot(pick);
                        s_q      <= gnt_to_sel(idx_to_onehot(pick));
                        busy_q   <= 1'b1;
                    end
                end
                default: begin
                    if (keep_owner) begin
                        if (hold_cnt < HOLD_LAST) begin
                            hold_cnt <= hold_cnt + 4'd1;
                        end
                    end else if (found) begin
                        // Forced rotation or direct handover: no idle cycle.
                        owner    <= pick;
                        last     <= pick;
                        hold_cnt <= 4'd0;
                        gnt_q    <= idx_to_onehot(pick);
                        s_q      <= gnt_to_sel(idx_to_onehot(pick));
                    end else begin
                        // s_q is left alone so the mux output stays stable.
                        state    <= IDLE;
                        hold_cnt <= 4'd0;
                        gnt_q    <= 3'b000;
                        busy_q   <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.s         = s_q;
    assign bus.busy      = busy_q;
    assign bus.state_dbg = state;

endmodule
